// File: rtl/enet_cfg_hub.sv
// Config-bus hub for NUM_CH Ethernet MAC channels: window decode, stall/ack
// handshake, read-data mux, per-channel station MAC and sticky masked IRQs.
module enet_cfg_hub #(
    parameter int          NUM_CH             = 2,
    parameter int          CH_ADDR_BITS       = 16,
    parameter logic [15:0] DEFAULT_MAC_ADDR_H = 16'h0000,
    parameter logic [31:0] DEFAULT_MAC_ADDR_L = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [31:0]              cfg_addr_i,
    input  logic [31:0]              cfg_data_wr_i,
    input  logic                     cfg_stb_i,
    input  logic                     cfg_we_i,
    output logic [31:0]              cfg_data_rd_o,
    output logic                     cfg_ack_o,
    output logic                     cfg_stall_o,
    output logic [NUM_CH-1:0]        ch_wr_o,
    output logic [CH_ADDR_BITS-1:0]  ch_addr_o,
    output logic [31:0]              ch_data_wr_o,
    input  logic [32*NUM_CH-1:0]     ch_tx_rd_i,
    input  logic [32*NUM_CH-1:0]     ch_rx_rd_i,
    input  logic [32*NUM_CH-1:0]     ch_ram_rd_i,
    input  logic [NUM_CH-1:0]        ch_busy_i,
    input  logic [NUM_CH-1:0]        ch_gie_i,
    input  logic [NUM_CH-1:0]        ch_tx_irq_i,
    input  logic [NUM_CH-1:0]        ch_rx_irq_i,
    input  logic [NUM_CH-1:0]        ch_mac_set_i,
    input  logic [48*NUM_CH-1:0]     ch_mac_addr_i,
    output logic [48*NUM_CH-1:0]     mac_addr_o,
    output logic                     intr_o
);

    localparam logic [47:0] MAC_BASE = {DEFAULT_MAC_ADDR_H, DEFAULT_MAC_ADDR_L};

    logic                    hub_hit;
    logic [1:0]              sel;
    logic                    ch_hit;
    logic [31:0]             off32;
    logic                    sel_busy;
    logic                    accept;
    logic                    ram_hit;
    logic [31:0]             rd_mux;
    logic [31:0]             ram_mux;
    logic                    ack_q;
    logic                    ram_q;
    logic [1:0]              sel_q;
    logic [31:0]             data_q;
    logic [NUM_CH-1:0]       status_q;
    logic [NUM_CH-1:0]       mask_q;
    logic [NUM_CH-1:0]       src;
    logic [NUM_CH-1:0]       w1c;
    logic [47:0]             mac_q [NUM_CH];
    logic                    unused_addr_hi;

    assign hub_hit        = cfg_addr_i[CH_ADDR_BITS+2];
    assign sel            = cfg_addr_i[CH_ADDR_BITS+1:CH_ADDR_BITS];
    assign ch_hit         = !hub_hit && (int'(sel) < NUM_CH);
    assign off32          = 32'(cfg_addr_i[CH_ADDR_BITS-1:0]);
    assign unused_addr_hi = ^cfg_addr_i[31:CH_ADDR_BITS+3];

    assign ch_addr_o    = cfg_addr_i[CH_ADDR_BITS-1:0];
    assign ch_data_wr_o = cfg_data_wr_i;

    assign ram_hit = ch_hit && ((off32 >= 32'h1000 && off32 <= 32'h16FF) ||
                                (off32 >= 32'h1800 && off32 <= 32'h1EFF));

    // Channel-side mux on the live address; hub and unmapped override below.
    always_comb begin
        sel_busy = 1'b0;
        rd_mux   = 32'h0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sel == 2'(c)) begin
                sel_busy = ch_busy_i[c];
                rd_mux   = (off32 < 32'h1000) ? ch_tx_rd_i[32*c +: 32]
                                              : ch_rx_rd_i[32*c +: 32];
            end
        end
        if (hub_hit) begin
            case (cfg_addr_i[7:0])
                8'h00:   rd_mux = 32'(status_q);
                8'h04:   rd_mux = 32'(mask_q);
                default: rd_mux = 32'h0;
            endcase
        end else if (!ch_hit) begin
            rd_mux = 32'h0;
        end
    end

    assign cfg_stall_o = ack_q | (ch_hit & sel_busy);
    assign accept      = cfg_stb_i & ~cfg_stall_o;

    always_comb begin
        ch_wr_o = '0;
        for (int c = 0; c < NUM_CH; c++)
            ch_wr_o[c] = accept & cfg_we_i & ch_hit & (sel == 2'(c));
    end

    always_comb begin
        ram_mux = 32'h0;
        for (int c = 0; c < NUM_CH; c++)
            if (sel_q == 2'(c))
                ram_mux = ch_ram_rd_i[32*c +: 32];
    end

    assign cfg_ack_o     = ack_q;
    assign cfg_data_rd_o = (ack_q & ram_q) ? ram_mux : data_q;

    assign src = ch_gie_i & (ch_tx_irq_i | ch_rx_irq_i);
    assign w1c = (accept & cfg_we_i & hub_hit & (cfg_addr_i[7:0] == 8'h00))
                 ? cfg_data_wr_i[NUM_CH-1:0] : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q    <= 1'b0;
            ram_q    <= 1'b0;
            sel_q    <= 2'b00;
            data_q   <= 32'h0;
            status_q <= '0;
            mask_q   <= '0;
            intr_o   <= 1'b0;
        end else begin
            ack_q <= accept;
            if (accept) begin
                data_q <= rd_mux;
                ram_q  <= ram_hit;
                sel_q  <= sel;
            end
            if (accept & cfg_we_i & hub_hit & (cfg_addr_i[7:0] == 8'h04))
                mask_q <= cfg_data_wr_i[NUM_CH-1:0];
            // A new source event beats a same-cycle clear.
            status_q <= src | (status_q & ~w1c);
            intr_o   <= |(status_q & mask_q);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CH; c++)
                mac_q[c] <= MAC_BASE + 48'(c);
        end else begin
            for (int c = 0; c < NUM_CH; c++)
                if (ch_mac_set_i[c])
                    mac_q[c] <= ch_mac_addr_i[48*c +: 48];
        end
    end

    always_comb begin
        mac_addr_o = '0;
        for (int c = 0; c < NUM_CH; c++)
            mac_addr_o[48*c +: 48] = mac_q[c];
    end

endmodule

// File: tb/tb_enet_cfg_hub.sv
// Self-checking bench for enet_cfg_hub: vector table, randomized transactions
// against a behavioural model, and hand-written stall/IRQ/MAC/reset sequences.
module tb_enet_cfg_hub;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [31:0]  cfg_addr_i = '0;
    logic [31:0]  cfg_data_wr_i = '0;
    logic         cfg_stb_i = 1'b0;
    logic         cfg_we_i = 1'b0;
    logic [31:0]  cfg_data_rd_o;
    logic         cfg_ack_o;
    logic         cfg_stall_o;
    logic [1:0]   ch_wr_o;
    logic [15:0]  ch_addr_o;
    logic [31:0]  ch_data_wr_o;
    logic [63:0]  ch_tx_rd_i, ch_rx_rd_i, ch_ram_rd_i;
    logic [1:0]   ch_busy_i = '0;
    logic [1:0]   ch_gie_i = '0;
    logic [1:0]   ch_tx_irq_i = '0;
    logic [1:0]   ch_rx_irq_i = '0;
    logic [1:0]   ch_mac_set_i = '0;
    logic [95:0]  ch_mac_addr_i = '0;
    logic [95:0]  mac_addr_o;
    logic         intr_o;

    logic [31:0] tx [2];
    logic [31:0] rx [2];
    logic [31:0] ram [2];
    assign ch_tx_rd_i  = {tx[1], tx[0]};
    assign ch_rx_rd_i  = {rx[1], rx[0]};
    assign ch_ram_rd_i = {ram[1], ram[0]};

    localparam logic [95:0] MAC_RST = {48'h0003_0000_0000, 48'h0002_FFFF_FFFF};

    enet_cfg_hub #(
        .NUM_CH(2), .CH_ADDR_BITS(16),
        .DEFAULT_MAC_ADDR_H(16'h0002), .DEFAULT_MAC_ADDR_L(32'hFFFF_FFFF)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_addr_i(cfg_addr_i), .cfg_data_wr_i(cfg_data_wr_i),
        .cfg_stb_i(cfg_stb_i), .cfg_we_i(cfg_we_i),
        .cfg_data_rd_o(cfg_data_rd_o), .cfg_ack_o(cfg_ack_o), .cfg_stall_o(cfg_stall_o),
        .ch_wr_o(ch_wr_o), .ch_addr_o(ch_addr_o), .ch_data_wr_o(ch_data_wr_o),
        .ch_tx_rd_i(ch_tx_rd_i), .ch_rx_rd_i(ch_rx_rd_i), .ch_ram_rd_i(ch_ram_rd_i),
        .ch_busy_i(ch_busy_i), .ch_gie_i(ch_gie_i),
        .ch_tx_irq_i(ch_tx_irq_i), .ch_rx_irq_i(ch_rx_irq_i),
        .ch_mac_set_i(ch_mac_set_i), .ch_mac_addr_i(ch_mac_addr_i),
        .mac_addr_o(mac_addr_o), .intr_o(intr_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    // Full request/response: drive at negedge, wait out stall, check strobe,
    // then sample the ack cycle at the following negedge.
    task automatic xfer(input string nm, input logic [31:0] addr, input bit we,
                        input logic [31:0] wd, input logic [1:0] exp_wr,
                        input bit chk_rd, input logic [31:0] exp_rd);
        int budget = 20;
        @(negedge clk_i);
        cfg_addr_i = addr; cfg_we_i = we; cfg_data_wr_i = wd; cfg_stb_i = 1'b1;
        #1;
        while (cfg_stall_o && budget > 0) begin
            @(negedge clk_i); #1;
            budget--;
        end
        if (budget == 0) chk({nm, "_stall_timeout"}, 96'(cfg_stall_o), 96'h0);
        chk({nm, "_wr"}, 96'(ch_wr_o), 96'(exp_wr));
        @(posedge clk_i); #1;
        cfg_stb_i = 1'b0; cfg_we_i = 1'b0;
        @(negedge clk_i);
        chk({nm, "_ack"}, 96'(cfg_ack_o), 96'h1);
        if (chk_rd) chk({nm, "_rd"}, 96'(cfg_data_rd_o), 96'(exp_rd));
    endtask

    typedef struct {
        string       nm;
        logic [31:0] addr;
        bit          we;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [1:0]  exp_wr;
    } vec_t;

    vec_t vecs [18];

    logic [31:0] a, wd, ex;
    logic [15:0] lo, off;
    logic [1:0]  s, ew, mask_m;
    bit          w;
    int          region;

    initial begin
        tx[0] = 32'hA0A0_0000; tx[1] = 32'hCAFE_0001;
        rx[0] = 32'hB0B0_0000; rx[1] = 32'hB1B1_0001;
        ram[0] = 32'h1234_5678; ram[1] = 32'h8765_4321;

        vecs[0]  = '{"ch1_tx_0004",   32'h0001_0004, 1'b0, 32'h0,         32'hCAFE_0001, 2'b00};
        vecs[1]  = '{"ch0_ram_1800",  32'h0000_1800, 1'b0, 32'h0,         32'h1234_5678, 2'b00};
        vecs[2]  = '{"ch0_rx_1F00",   32'h0000_1F00, 1'b0, 32'h0,         32'hB0B0_0000, 2'b00};
        vecs[3]  = '{"ch0_ram_16FF",  32'h0000_16FF, 1'b0, 32'h0,         32'h1234_5678, 2'b00};
        vecs[4]  = '{"ch0_rx_1700",   32'h0000_1700, 1'b0, 32'h0,         32'hB0B0_0000, 2'b00};
        vecs[5]  = '{"ch0_ram_1EFF",  32'h0000_1EFF, 1'b0, 32'h0,         32'h1234_5678, 2'b00};
        vecs[6]  = '{"ch1_tx_0FFC",   32'h0001_0FFC, 1'b0, 32'h0,         32'hCAFE_0001, 2'b00};
        vecs[7]  = '{"ch1_ram_1000",  32'h0001_1000, 1'b0, 32'h0,         32'h8765_4321, 2'b00};
        vecs[8]  = '{"ch1_write",     32'h0001_0008, 1'b1, 32'h5555_AAAA, 32'h0,         2'b10};
        vecs[9]  = '{"ch0_write",     32'h0000_0010, 1'b1, 32'h1111_2222, 32'h0,         2'b01};
        vecs[10] = '{"unmap3_write",  32'h0003_0000, 1'b1, 32'hDEAD_BEEF, 32'h0,         2'b00};
        vecs[11] = '{"unmap3_read",   32'h0003_0004, 1'b0, 32'h0,         32'h0,         2'b00};
        vecs[12] = '{"unmap2_read",   32'h0002_0000, 1'b0, 32'h0,         32'h0,         2'b00};
        vecs[13] = '{"hub_mask_wr",   32'h0004_0004, 1'b1, 32'hFFFF_FFFF, 32'h0,         2'b00};
        vecs[14] = '{"hub_mask_rd",   32'h0004_0004, 1'b0, 32'h0,         32'h0000_0003, 2'b00};
        vecs[15] = '{"hub_status_rd", 32'h0004_0000, 1'b0, 32'h0,         32'h0,         2'b00};
        vecs[16] = '{"hub_other_rd",  32'h0004_0008, 1'b0, 32'h0,         32'h0,         2'b00};
        vecs[17] = '{"hub_mask_clr",  32'h0004_0004, 1'b1, 32'h0,         32'h0,         2'b00};

        repeat (3) @(negedge clk_i);
        chk("rst_ack",   96'(cfg_ack_o),     96'h0);
        chk("rst_rd",    96'(cfg_data_rd_o), 96'h0);
        chk("rst_intr",  96'(intr_o),        96'h0);
        chk("rst_stall", 96'(cfg_stall_o),   96'h0);
        chk("rst_mac",   mac_addr_o,         MAC_RST);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("idle_wr",   96'(ch_wr_o),       96'h0);
        chk("idle_intr", 96'(intr_o),        96'h0);

        for (int i = 0; i < 18; i++)
            xfer(vecs[i].nm, vecs[i].addr, vecs[i].we, vecs[i].wd,
                 vecs[i].exp_wr, !vecs[i].we, vecs[i].exp_rd);
        @(negedge clk_i);
        chk("ack_single", 96'(cfg_ack_o), 96'h0);

        // Randomized transactions against a spec-level model (no IRQ activity).
        mask_m = 2'b00;
        for (int i = 0; i < 200; i++) begin
            tx[0] = $urandom; tx[1] = $urandom; rx[0] = $urandom; rx[1] = $urandom;
            ram[0] = $urandom; ram[1] = $urandom;
            region = $urandom_range(0, 4);
            w  = 1'($urandom_range(0, 1));
            wd = $urandom;
            off = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(32'h0FF0, 32'h1F10))
                                              : 16'($urandom);
            if (region == 4)
                a = 32'h0004_0000 | ($urandom & 32'h0003_FF00) | 32'($urandom_range(0, 3) * 4);
            else
                a = (32'(region) << 16) | 32'(off);
            s  = a[17:16];
            lo = a[15:0];
            ew = 2'b00;
            ex = 32'h0;
            if (a[18]) begin
                if (a[7:0] == 8'h04) ex = 32'(mask_m);
                if (w && a[7:0] == 8'h04) mask_m = wd[1:0];
            end else if (s < 2) begin
                if (w) ew = 2'b01 << s;
                if (lo < 16'h1000) ex = tx[s];
                else if ((lo <= 16'h16FF) || (lo >= 16'h1800 && lo <= 16'h1EFF)) ex = ram[s];
                else ex = rx[s];
            end
            xfer("rand", a, w, wd, ew, !w, ex);
        end

        tx[0] = 32'hA0A0_0000; tx[1] = 32'hCAFE_0001;
        rx[0] = 32'hB0B0_0000; rx[1] = 32'hB1B1_0001;
        xfer("mask_zero", 32'h0004_0004, 1'b1, 32'h0, 2'b00, 1'b0, 32'h0);

        // Busy channel stalls; other channel still served; released request completes.
        ch_busy_i = 2'b10;
        @(negedge clk_i);
        cfg_addr_i = 32'h0001_0004; cfg_we_i = 1'b0; cfg_stb_i = 1'b1;
        #1 chk("busy_stall", 96'(cfg_stall_o), 96'h1);
        repeat (3) @(negedge clk_i);
        chk("busy_stall_held", 96'(cfg_stall_o), 96'h1);
        chk("busy_no_ack",     96'(cfg_ack_o),   96'h0);
        cfg_stb_i = 1'b0;
        xfer("busy_ch0_wr", 32'h0000_0020, 1'b1, 32'h0BAD_F00D, 2'b01, 1'b0, 32'h0);
        @(negedge clk_i);
        cfg_addr_i = 32'h0001_0004; cfg_we_i = 1'b0; cfg_stb_i = 1'b1;
        #1 chk("busy_stall2", 96'(cfg_stall_o), 96'h1);
        @(negedge clk_i);
        ch_busy_i = 2'b00;
        #1 chk("busy_release", 96'(cfg_stall_o), 96'h0);
        @(posedge clk_i); #1 cfg_stb_i = 1'b0;
        @(negedge clk_i);
        chk("busy_ack",  96'(cfg_ack_o),     96'h1);
        chk("busy_data", 96'(cfg_data_rd_o), 96'hCAFE_0001);

        // Sticky W1C interrupt path.
        ch_gie_i = 2'b11;
        xfer("irq_mask1", 32'h0004_0004, 1'b1, 32'h1, 2'b00, 1'b0, 32'h0);
        @(negedge clk_i); ch_rx_irq_i[0] = 1'b1;
        @(negedge clk_i); ch_rx_irq_i[0] = 1'b0;
        chk("irq_lat1", 96'(intr_o), 96'h0);
        @(negedge clk_i);
        chk("irq_lat2", 96'(intr_o), 96'h1);
        repeat (3) @(negedge clk_i);
        chk("irq_sticky", 96'(intr_o), 96'h1);
        xfer("irq_stat1", 32'h0004_0000, 1'b0, 32'h0, 2'b00, 1'b1, 32'h1);
        xfer("irq_w1c",   32'h0004_0000, 1'b1, 32'h1, 2'b00, 1'b0, 32'h0);
        @(negedge clk_i);
        chk("irq_cleared", 96'(intr_o), 96'h0);
        xfer("irq_stat0", 32'h0004_0000, 1'b0, 32'h0, 2'b00, 1'b1, 32'h0);
        ch_rx_irq_i[0] = 1'b1;
        repeat (2) @(negedge clk_i);
        xfer("irq_w1c_hold", 32'h0004_0000, 1'b1, 32'h1, 2'b00, 1'b0, 32'h0);
        xfer("irq_stat_hold", 32'h0004_0000, 1'b0, 32'h0, 2'b00, 1'b1, 32'h1);
        chk("irq_hold_intr", 96'(intr_o), 96'h1);
        ch_rx_irq_i[0] = 1'b0;
        xfer("irq_w1c2", 32'h0004_0000, 1'b1, 32'h1, 2'b00, 1'b0, 32'h0);
        @(negedge clk_i); ch_tx_irq_i[1] = 1'b1;
        @(negedge clk_i); ch_tx_irq_i[1] = 1'b0;
        repeat (2) @(negedge clk_i);
        xfer("irq_stat_ch1", 32'h0004_0000, 1'b0, 32'h0, 2'b00, 1'b1, 32'h2);
        chk("irq_masked", 96'(intr_o), 96'h0);
        xfer("irq_mask3", 32'h0004_0004, 1'b1, 32'h3, 2'b00, 1'b0, 32'h0);
        chk("irq_mask_lat1", 96'(intr_o), 96'h0);
        @(negedge clk_i);
        chk("irq_mask_lat2", 96'(intr_o), 96'h1);
        xfer("irq_w1c3", 32'h0004_0000, 1'b1, 32'h3, 2'b00, 1'b0, 32'h0);
        ch_gie_i = 2'b00;
        @(negedge clk_i); ch_tx_irq_i = 2'b11; ch_rx_irq_i = 2'b11;
        @(negedge clk_i); ch_tx_irq_i = 2'b00; ch_rx_irq_i = 2'b00;
        xfer("irq_gie_off", 32'h0004_0000, 1'b0, 32'h0, 2'b00, 1'b1, 32'h0);

        // MAC updates: simultaneous, then single channel.
        @(negedge clk_i);
        ch_mac_set_i = 2'b11;
        ch_mac_addr_i = {48'h1111_2222_3333, 48'h4444_5555_6666};
        @(negedge clk_i);
        ch_mac_set_i = 2'b00;
        chk("mac_both", mac_addr_o, {48'h1111_2222_3333, 48'h4444_5555_6666});
        ch_mac_set_i = 2'b01;
        ch_mac_addr_i = {48'hAAAA_AAAA_AAAA, 48'h0123_4567_89AB};
        @(negedge clk_i);
        ch_mac_set_i = 2'b00;
        chk("mac_ch0", mac_addr_o, {48'h1111_2222_3333, 48'h0123_4567_89AB});

        // Reset while an ack is pending: response is dropped.
        @(negedge clk_i);
        cfg_addr_i = 32'h0001_0004; cfg_we_i = 1'b0; cfg_stb_i = 1'b1;
        @(posedge clk_i); #1;
        chk("rst_mid_pre", 96'(cfg_ack_o), 96'h1);
        rst_i = 1'b1; cfg_stb_i = 1'b0;
        #1;
        chk("rst_mid_ack", 96'(cfg_ack_o),     96'h0);
        chk("rst_mid_rd",  96'(cfg_data_rd_o), 96'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_mid_noack", 96'(cfg_ack_o), 96'h0);
        chk("rst_mid_mac",   mac_addr_o,     MAC_RST);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
